// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Load/store has priority, fetch is protected from starvation, and a watchdog aborts accesses the memory never acknowledges.
module mem_port_arbiter #(
    parameter int unsigned MAX_LS_STREAK = 4,
    parameter int unsigned TIMEOUT       = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_ls_req,
    input  logic        i_ls_wren,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_bmask,
    output logic        o_ls_gnt,
    output logic        o_ls_rvalid,
    output logic [31:0] o_ls_rdata,
    output logic        o_mem_req,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_bus_err,
    output logic        o_busy
);

    localparam int unsigned STREAK_W = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
    localparam int unsigned WDOG_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        IF_ACC,
        LS_ACC
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic [WDOG_W-1:0]   wdog;
    logic                abort_if;
    logic                abort_ls;
    logic                if_win;
    logic                ls_win;
    logic                streak_full;

    // Fetch words are always aligned, so the byte offset is dropped.
    logic unused_if_addr_lsbs;
    assign unused_if_addr_lsbs = ^i_if_addr[1:0];

    // Arbitration is resolved in the IDLE cycle itself so the grant can go out immediately.
    assign streak_full = (streak == STREAK_W'(MAX_LS_STREAK));
    assign if_win      = i_reset && (state == IDLE) && i_if_req && (!i_ls_req || streak_full);
    assign ls_win      = i_reset && (state == IDLE) && i_ls_req && !if_win;
    assign o_if_gnt    = if_win;
    assign o_ls_gnt    = ls_win;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state       <= IDLE;
            streak      <= '0;
            wdog        <= '0;
            abort_if    <= 1'b0;
            abort_ls    <= 1'b0;
            o_if_rvalid <= 1'b0;
            o_if_rdata  <= '0;
            o_ls_rvalid <= 1'b0;
            o_ls_rdata  <= '0;
            o_mem_req   <= 1'b0;
            o_mem_wren  <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_bmask <= '0;
            o_bus_err   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_if_rvalid <= 1'b0;
            o_ls_rvalid <= 1'b0;
            o_bus_err   <= 1'b0;
            abort_if    <= 1'b0;
            abort_ls    <= 1'b0;

            // An aborted access reports its error one cycle after the memory request is dropped.
            if (abort_if) begin
                o_if_rvalid <= 1'b1;
                o_if_rdata  <= ABORT_DATA;
                o_bus_err   <= 1'b1;
            end
            if (abort_ls) begin
                o_ls_rvalid <= 1'b1;
                o_ls_rdata  <= ABORT_DATA;
                o_bus_err   <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (if_win) begin
                        state       <= IF_ACC;
                        o_mem_req   <= 1'b1;
                        o_mem_wren  <= 1'b0;
                        o_mem_addr  <= {i_if_addr[31:2], 2'b00};
                        o_mem_wdata <= '0;
                        o_mem_bmask <= 4'hF;
                        o_busy      <= 1'b1;
                        wdog        <= '0;
                        streak      <= '0;
                    end else if (ls_win) begin
                        state       <= LS_ACC;
                        o_mem_req   <= 1'b1;
                        o_mem_wren  <= i_ls_wren;
                        o_mem_addr  <= i_ls_addr;
                        o_mem_wdata <= i_ls_wdata;
                        o_mem_bmask <= i_ls_bmask;
                        o_busy      <= 1'b1;
                        wdog        <= '0;
                        if (!i_if_req) begin
                            streak <= '0;
                        end else if (!streak_full) begin
                            streak <= streak + STREAK_W'(1);
                        end
                    end
                end
                IF_ACC, LS_ACC: begin
                    if (i_mem_ack) begin
                        state     <= IDLE;
                        o_mem_req <= 1'b0;
                        o_busy    <= 1'b0;
                        if (state == IF_ACC) begin
                            o_if_rvalid <= 1'b1;
                            o_if_rdata  <= i_mem_rdata;
                        end else begin
                            o_ls_rvalid <= 1'b1;
                            o_ls_rdata  <= o_mem_wren ? 32'h0 : i_mem_rdata;
                        end
                    end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
                        state     <= IDLE;
                        o_mem_req <= 1'b0;
                        o_busy    <= 1'b0;
                        wdog      <= WDOG_W'(TIMEOUT);
                        abort_if  <= (state == IF_ACC);
                        abort_ls  <= (state == LS_ACC);
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_mem_req <= 1'b0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by a randomized run against a cycle-accounting model of the arbiter.
module tb_mem_port_arbiter;

    localparam int unsigned MAX_LS_STREAK = 4;
    localparam int unsigned TIMEOUT       = 15;
    localparam int          N_RAND        = 3000;

    logic        i_clk;
    logic        i_reset;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_ls_req;
    logic        i_ls_wren;
    logic [31:0] i_ls_addr;
    logic [31:0] i_ls_wdata;
    logic [3:0]  i_ls_bmask;
    logic        o_ls_gnt;
    logic        o_ls_rvalid;
    logic [31:0] o_ls_rdata;
    logic        o_mem_req;
    logic        o_mem_wren;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_bus_err;
    logic        o_busy;

    mem_port_arbiter #(
        .MAX_LS_STREAK(MAX_LS_STREAK),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_if_req   (i_if_req),
        .i_if_addr  (i_if_addr),
        .o_if_gnt   (o_if_gnt),
        .o_if_rvalid(o_if_rvalid),
        .o_if_rdata (o_if_rdata),
        .i_ls_req   (i_ls_req),
        .i_ls_wren  (i_ls_wren),
        .i_ls_addr  (i_ls_addr),
        .i_ls_wdata (i_ls_wdata),
        .i_ls_bmask (i_ls_bmask),
        .o_ls_gnt   (o_ls_gnt),
        .o_ls_rvalid(o_ls_rvalid),
        .o_ls_rdata (o_ls_rdata),
        .o_mem_req  (o_mem_req),
        .o_mem_wren (o_mem_wren),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_mem_bmask(o_mem_bmask),
        .i_mem_ack  (i_mem_ack),
        .i_mem_rdata(i_mem_rdata),
        .o_bus_err  (o_bus_err),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge i_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge i_clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid,
                                 o_mem_req, o_mem_wren, o_bus_err, o_busy}), 32'h0);
        chk({tag, "_data"}, o_if_rdata | o_ls_rdata | o_mem_addr | o_mem_wdata, 32'h0);
        chk({tag, "_bmask"}, 32'(o_mem_bmask), 32'h0);
    endtask

    // Model state for the randomized run: memory occupancy is tracked as cycle windows.
    typedef struct {
        int          cyc;
        bit          is_if;
        logic [31:0] data;
        bit          err;
    } ev_t;

    ev_t         ev_q[$];
    int          idle_at, acc_first, acc_last, ack_cyc, streak_m, d;
    logic [31:0] ack_data, exp_addr, exp_wdata, e_data;
    logic [3:0]  exp_bmask;
    logic        exp_wren, exp_is_if;
    bit          if_granted, ls_granted, idle_m, w_if, w_ls, mreq, e_if, e_ls, e_err;

    int          req_cnt, rv_at, err_cnt;
    logic [31:0] rv_data;
    logic        rv_err, gnt_seen;

    initial begin
        i_reset     = 1'b0;
        i_if_req    = 1'b0;
        i_if_addr   = '0;
        i_ls_req    = 1'b0;
        i_ls_wren   = 1'b0;
        i_ls_addr   = '0;
        i_ls_wdata  = '0;
        i_ls_bmask  = '0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;

        repeat (2) @(posedge i_clk);
        #1;
        smp();
        chk_all_zero("reset");
        nxt();
        i_reset = 1'b1;
        nxt();

        // Fetch only.
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0106;
        smp();
        chk("t1_if_gnt", 32'(o_if_gnt), 32'h1);
        chk("t1_ls_gnt", 32'(o_ls_gnt), 32'h0);
        nxt();
        i_if_req    = 1'b0;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h0010_0093;
        smp();
        chk("t1_mem_req", 32'(o_mem_req), 32'h1);
        chk("t1_mem_addr", o_mem_addr, 32'h104);
        chk("t1_mem_bmask", 32'(o_mem_bmask), 32'hF);
        chk("t1_mem_wren", 32'(o_mem_wren), 32'h0);
        chk("t1_busy", 32'(o_busy), 32'h1);
        nxt();
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        smp();
        chk("t1_if_rvalid", 32'(o_if_rvalid), 32'h1);
        chk("t1_if_rdata", o_if_rdata, 32'h0010_0093);
        chk("t1_ls_rvalid", 32'(o_ls_rvalid), 32'h0);
        chk("t1_mem_req_low", 32'(o_mem_req), 32'h0);
        nxt();

        // Store and fetch in the same cycle.
        i_if_req   = 1'b1;
        i_if_addr  = 32'h40;
        i_ls_req   = 1'b1;
        i_ls_wren  = 1'b1;
        i_ls_addr  = 32'h200;
        i_ls_wdata = 32'hA5A5_A5A5;
        i_ls_bmask = 4'h3;
        smp();
        chk("t2_ls_gnt", 32'(o_ls_gnt), 32'h1);
        chk("t2_if_gnt", 32'(o_if_gnt), 32'h0);
        nxt();
        i_ls_req    = 1'b0;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h1234_5678;
        smp();
        chk("t2_mem_wren", 32'(o_mem_wren), 32'h1);
        chk("t2_mem_addr", o_mem_addr, 32'h200);
        chk("t2_mem_wdata", o_mem_wdata, 32'hA5A5_A5A5);
        chk("t2_mem_bmask", 32'(o_mem_bmask), 32'h3);
        chk("t2_if_gnt_busy", 32'(o_if_gnt), 32'h0);
        nxt();
        i_mem_ack = 1'b0;
        smp();
        chk("t2_ls_rvalid", 32'(o_ls_rvalid), 32'h1);
        chk("t2_ls_rdata", o_ls_rdata, 32'h0);
        chk("t2_if_gnt_next", 32'(o_if_gnt), 32'h1);
        nxt();
        i_if_req    = 1'b0;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hCAFE_F00D;
        smp();
        chk("t2_if_mem_addr", o_mem_addr, 32'h40);
        chk("t2_if_mem_wren", 32'(o_mem_wren), 32'h0);
        nxt();
        i_mem_ack = 1'b0;
        smp();
        chk("t2_if_rdata", o_if_rdata, 32'hCAFE_F00D);
        nxt();

        // Starvation guard: both held, memory acks at once.
        i_if_req   = 1'b1;
        i_if_addr  = 32'h80;
        i_ls_req   = 1'b1;
        i_ls_wren  = 1'b0;
        i_ls_addr  = 32'h600;
        i_mem_ack  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            smp();
            chk($sformatf("t3_if_gnt_%0d", k), 32'(o_if_gnt), 32'(k == 8));
            chk($sformatf("t3_ls_gnt_%0d", k), 32'(o_ls_gnt), 32'((k % 2 == 0) && (k != 8)));
            nxt();
        end
        i_if_req  = 1'b0;
        i_ls_req  = 1'b0;
        i_mem_ack = 1'b0;
        smp();
        chk("t3_last_rvalid", 32'(o_ls_rvalid), 32'h1);
        nxt();

        // Watchdog abort of a load that is never acknowledged.
        i_ls_req  = 1'b1;
        i_ls_wren = 1'b0;
        i_ls_addr = 32'h300;
        smp();
        chk("t4_ls_gnt", 32'(o_ls_gnt), 32'h1);
        nxt();
        i_ls_req = 1'b0;
        req_cnt  = 0;
        rv_at    = -1;
        err_cnt  = 0;
        rv_data  = '0;
        rv_err   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            smp();
            if (o_mem_req) req_cnt++;
            if (o_bus_err) err_cnt++;
            if (o_ls_rvalid && rv_at < 0) begin
                rv_at   = i;
                rv_data = o_ls_rdata;
                rv_err  = o_bus_err;
            end
            nxt();
        end
        chk("t4_req_cycles", 32'(req_cnt), 32'd15);
        chk("t4_rvalid_cycle", 32'(rv_at), 32'd17);
        chk("t4_rdata", rv_data, 32'hDEAD_BEEF);
        chk("t4_bus_err", 32'(rv_err), 32'h1);
        chk("t4_bus_err_cycles", 32'(err_cnt), 32'h1);

        // Reset while a load is in flight, then a late ack.
        i_ls_req  = 1'b1;
        i_ls_addr = 32'h400;
        smp();
        chk("t5_ls_gnt", 32'(o_ls_gnt), 32'h1);
        nxt();
        i_ls_req = 1'b0;
        i_reset  = 1'b0;
        smp();
        chk("t5_mem_req_before", 32'(o_mem_req), 32'h1);
        nxt();
        i_reset     = 1'b1;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h77;
        smp();
        chk_all_zero("t5_after_reset");
        nxt();
        i_mem_ack = 1'b0;
        smp();
        chk("t5_no_rvalid", 32'({o_ls_rvalid, o_if_rvalid}), 32'h0);
        nxt();
        i_if_req  = 1'b1;
        i_if_addr = 32'h500;
        smp();
        chk("t5_if_gnt", 32'(o_if_gnt), 32'h1);
        nxt();
        i_if_req    = 1'b0;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h13;
        smp();
        chk("t5_mem_addr", o_mem_addr, 32'h500);
        nxt();
        i_mem_ack = 1'b0;
        smp();
        chk("t5_if_rvalid", 32'(o_if_rvalid), 32'h1);
        chk("t5_if_rdata", o_if_rdata, 32'h13);
        nxt();

        // Fetch request withdrawn while load/store owns the memory.
        i_ls_req   = 1'b1;
        i_ls_wren  = 1'b1;
        i_ls_addr  = 32'h700;
        i_ls_wdata = 32'h1;
        i_ls_bmask = 4'hF;
        smp();
        chk("t6_ls_gnt", 32'(o_ls_gnt), 32'h1);
        nxt();
        i_ls_req  = 1'b0;
        i_if_req  = 1'b1;
        i_if_addr = 32'h900;
        smp();
        gnt_seen = o_if_gnt;
        nxt();
        i_if_req  = 1'b0;
        i_mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            smp();
            gnt_seen = gnt_seen | o_if_gnt;
            nxt();
            i_mem_ack = 1'b0;
        end
        chk("t6_no_if_gnt", 32'(gnt_seen), 32'h0);

        // Randomized traffic against the model.
        i_reset = 1'b0;
        nxt();
        i_reset    = 1'b1;
        idle_at    = 0;
        acc_first  = -100;
        acc_last   = -100;
        ack_cyc    = -100;
        streak_m   = 0;
        if_granted = 1'b0;
        ls_granted = 1'b0;
        ack_data   = '0;
        exp_addr   = '0;
        exp_wdata  = '0;
        exp_bmask  = '0;
        exp_wren   = 1'b0;
        exp_is_if  = 1'b0;
        ev_q.delete();
        for (int cyc = 0; cyc < N_RAND; cyc++) begin
            if (if_granted) begin
                i_if_req   = 1'b0;
                if_granted = 1'b0;
            end else if (!i_if_req) begin
                if ($urandom_range(2) == 0) begin
                    i_if_req  = 1'b1;
                    i_if_addr = $urandom;
                end
            end else if ($urandom_range(19) == 0) begin
                i_if_req = 1'b0;
            end
            if (ls_granted) begin
                i_ls_req   = 1'b0;
                ls_granted = 1'b0;
            end else if (!i_ls_req) begin
                if ($urandom_range(2) == 0) begin
                    i_ls_req   = 1'b1;
                    i_ls_wren  = 1'($urandom_range(1));
                    i_ls_addr  = $urandom;
                    i_ls_wdata = $urandom;
                    i_ls_bmask = 4'($urandom);
                end
            end else if ($urandom_range(19) == 0) begin
                i_ls_req = 1'b0;
            end
            if (cyc == ack_cyc) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = ack_data;
            end else begin
                i_mem_rdata = $urandom;
                i_mem_ack   = (cyc >= idle_at) && ($urandom_range(7) == 0);
            end

            smp();
            idle_m = (cyc >= idle_at);
            w_if   = idle_m && i_if_req && (!i_ls_req || streak_m == int'(MAX_LS_STREAK));
            w_ls   = idle_m && i_ls_req && !w_if;
            chk("r_if_gnt", 32'(o_if_gnt), 32'(w_if));
            chk("r_ls_gnt", 32'(o_ls_gnt), 32'(w_ls));
            chk("r_busy", 32'(o_busy), 32'(!idle_m));
            mreq = (cyc >= acc_first) && (cyc <= acc_last);
            chk("r_mem_req", 32'(o_mem_req), 32'(mreq));
            if (mreq) begin
                chk("r_mem_addr", o_mem_addr, exp_addr);
                chk("r_mem_wren", 32'(o_mem_wren), 32'(exp_wren));
                chk("r_mem_bmask", 32'(o_mem_bmask), 32'(exp_bmask));
                if (!exp_is_if) chk("r_mem_wdata", o_mem_wdata, exp_wdata);
            end
            e_if   = 1'b0;
            e_ls   = 1'b0;
            e_err  = 1'b0;
            e_data = '0;
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                e_if   = ev_q[0].is_if;
                e_ls   = !ev_q[0].is_if;
                e_err  = ev_q[0].err;
                e_data = ev_q[0].data;
                void'(ev_q.pop_front());
            end
            chk("r_if_rvalid", 32'(o_if_rvalid), 32'(e_if));
            chk("r_ls_rvalid", 32'(o_ls_rvalid), 32'(e_ls));
            chk("r_bus_err", 32'(o_bus_err), 32'(e_err));
            if (e_if) chk("r_if_rdata", o_if_rdata, e_data);
            if (e_ls) chk("r_ls_rdata", o_ls_rdata, e_data);

            if (w_if || w_ls) begin
                d         = ($urandom_range(9) == 0) ? int'(TIMEOUT) : int'($urandom_range(4));
                ack_data  = $urandom;
                acc_first = cyc + 1;
                ack_cyc   = cyc + 1 + d;
                exp_is_if = w_if;
                if (w_if) begin
                    exp_addr  = {i_if_addr[31:2], 2'b00};
                    exp_wren  = 1'b0;
                    exp_bmask = 4'hF;
                    exp_wdata = '0;
                end else begin
                    exp_addr  = i_ls_addr;
                    exp_wren  = i_ls_wren;
                    exp_bmask = i_ls_bmask;
                    exp_wdata = i_ls_wdata;
                end
                if (d < int'(TIMEOUT)) begin
                    acc_last = cyc + 1 + d;
                    idle_at  = cyc + 2 + d;
                    ev_q.push_back('{cyc + 2 + d, w_if, (w_ls && i_ls_wren) ? 32'h0 : ack_data, 1'b0});
                end else begin
                    acc_last = cyc + int'(TIMEOUT);
                    idle_at  = cyc + int'(TIMEOUT) + 1;
                    ev_q.push_back('{cyc + int'(TIMEOUT) + 2, w_if, 32'hDEAD_BEEF, 1'b1});
                end
                if (w_if || !i_if_req) streak_m = 0;
                else if (streak_m < int'(MAX_LS_STREAK)) streak_m++;
                if_granted = w_if;
                ls_granted = w_ls;
            end
            nxt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
